// File: rtl/marmot_uart_pkg.sv
// rtl/marmot_uart_pkg.sv - shared state type and constants for the Marmot UART transmitter
package marmot_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

endpackage

// File: rtl/marmot_uart_tx_fifo.sv
// rtl/marmot_uart_tx_fifo.sv - byte FIFO feeding the UART transmitter
// Head data is read combinationally from storage; full/empty derive from the count.
module marmot_uart_tx_fifo
  import marmot_uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_count == FULL_COUNT);
  assign empty = (r_count == '0);

  // A full FIFO refuses a push even when the same edge pops a byte out.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

endmodule

// File: rtl/marmot_uart_tx.sv
// rtl/marmot_uart_tx.sv - UART transmitter (8N1/8N2) with input FIFO
// Defining UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
module marmot_uart_tx
  import marmot_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  in_data,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [2:0]         LAST_DATA  = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]         LAST_STOP  = 3'(STOP_BITS - 1);

  uart_tx_state_e            r_state;
  logic [TIMER_W-1:0]        r_timer;
  logic [2:0]                r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_sh;
  logic                      r_txd;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity;
`endif

  logic                      w_push;
  logic                      w_pop;
  logic                      w_bit_end;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [UART_DATA_BITS-1:0] w_head;

  assign in_ready  = !w_fifo_full;
  assign w_push    = in_valid && in_ready;
  assign w_bit_end = (r_timer == '0);

  // Pop from IDLE, or straight out of the final stop bit so frames run back to back.
  assign w_pop = !w_fifo_empty &&
                 ((r_state == IDLE) ||
                  ((r_state == STOP) && w_bit_end && (r_bit_idx == LAST_STOP)));

  marmot_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (in_data),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_sh      <= '0;
      r_txd     <= 1'b1;
    end else if (w_pop) begin
      r_state   <= START;
      r_timer   <= TIMER_LOAD;
      r_bit_idx <= '0;
      r_sh      <= w_head;
      r_txd     <= 1'b0;
    end else begin
      case (r_state)
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_timer <= TIMER_LOAD;
            r_txd   <= r_sh[0];
          end else begin
            r_timer <= r_timer - TIMER_ONE;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_timer <= TIMER_LOAD;
            if (r_bit_idx == LAST_DATA) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= PARITY;
              r_txd     <= r_parity;
`else
              r_state   <= STOP;
              r_txd     <= 1'b1;
`endif
            end else begin
              // The line always carries sh[0]; shift first, so drive the next bit now.
              r_bit_idx <= r_bit_idx + 3'd1;
              r_sh      <= {1'b0, r_sh[UART_DATA_BITS-1:1]};
              r_txd     <= r_sh[1];
            end
          end else begin
            r_timer <= r_timer - TIMER_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_state   <= STOP;
            r_timer   <= TIMER_LOAD;
            r_bit_idx <= '0;
            r_txd     <= 1'b1;
          end else begin
            r_timer <= r_timer - TIMER_ONE;
          end
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            r_timer <= TIMER_LOAD;
            if (r_bit_idx == LAST_STOP) begin
              r_state   <= IDLE;
              r_bit_idx <= '0;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_timer <= r_timer - TIMER_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= ^w_head;
    end
  end
`endif

  assign txd  = r_txd;
  assign busy = (r_state != IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_marmot_uart_tx.sv
// tb/tb_marmot_uart_tx.sv - directed self-checking bench for marmot_uart_tx
module tb_marmot_uart_tx;

  localparam int CPB = 217;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F1 = (10 + P) * CPB;
  localparam int F2 = (11 + P) * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_valid2;
  logic [7:0] in_data, in_data2;
  logic       in_ready, in_ready2;
  logic       txd, txd2;
  logic       busy, busy2;
  logic [3:0] fifo_count, fifo_count2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  marmot_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .STOP_BITS(1)) dut (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .txd(txd), .busy(busy), .fifo_count(fifo_count)
  );

  marmot_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .STOP_BITS(2)) dut2 (
    .clock(clk), .reset(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .txd(txd2), .busy(busy2), .fifo_count(fifo_count2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference receiver per line: samples mid-bit, records frame bits and start cycle.
  int          m_ph [2] = '{-1, -1};
  logic [11:0] m_bits [2];
  int          m_t [2];
  int          starts0 = 0;
  logic [11:0] q0_f[$];
  int          q0_t[$];
  logic [11:0] q1_f[$];
  int          q1_t[$];

  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      logic ln;
      int   nb;
      int   k;
      ln = (w == 0) ? txd : txd2;
      nb = (w == 0) ? 10 + P : 11 + P;
      if (rst) begin
        m_ph[w] = -1;
      end else if (m_ph[w] < 0) begin
        if (ln === 1'b0) begin
          m_ph[w]   = 0;
          m_bits[w] = '1;
          m_t[w]    = cyc;
          if (w == 0) starts0++;
        end
      end else begin
        m_ph[w]++;
      end
      if (m_ph[w] >= 108 && ((m_ph[w] - 108) % CPB) == 0) begin
        k = (m_ph[w] - 108) / CPB;
        m_bits[w][k] = ln;
        if (k == nb - 1) begin
          if (w == 0) begin q0_f.push_back(m_bits[w]); q0_t.push_back(m_t[w]); end
          else        begin q1_f.push_back(m_bits[w]); q1_t.push_back(m_t[w]); end
          m_ph[w] = -1;
        end
      end
    end
  end

  function automatic logic [11:0] exp_frame(input logic [7:0] b);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (P == 1) f[9] = ^b;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic rx(input int w, input string tag, input logic [7:0] b, output int t);
    int          n;
    int          sz;
    logic [11:0] f;
    n  = 0;
    sz = (w == 0) ? q0_f.size() : q1_f.size();
    while (sz == 0 && n < 6000) begin
      @(negedge clk);
      n++;
      sz = (w == 0) ? q0_f.size() : q1_f.size();
    end
    chk({tag, "_arrived"}, 32'(sz != 0), 32'd1);
    t = -1;
    if (sz != 0) begin
      if (w == 0) begin f = q0_f.pop_front(); t = q0_t.pop_front(); end
      else        begin f = q1_f.pop_front(); t = q1_t.pop_front(); end
      chk(tag, 32'(f), 32'(exp_frame(b)));
    end
  endtask

  initial begin
    int c0, p1, t, tp, n, s0, qs, t2, s;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_valid2 = 1'b0; in_data2 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_txd2", 32'(txd2), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0xA5: latency, start width, first data bit, busy window.
    in_data = 8'hA5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; c0 = cyc;
    chk("a5_txd_before_pop", 32'(txd), 32'd1);
    chk("a5_busy_rise", 32'(busy), 32'd1);
    chk("a5_count_after_push", 32'(fifo_count), 32'd1);
    @(negedge clk);
    chk("a5_start_low", 32'(txd), 32'd0);
    chk("a5_count_after_pop", 32'(fifo_count), 32'd0);
    repeat (CPB - 1) @(negedge clk);
    chk("a5_start_last_cycle", 32'(txd), 32'd0);
    @(negedge clk);
    chk("a5_bit0", 32'(txd), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 4000) begin @(negedge clk); n++; end
    chk("a5_busy_fall_time", 32'(cyc - c0), 32'(F1 + 1));
    rx(0, "a5_frame", 8'hA5, t);

    // Burst of 9 bytes with in_valid held high; FIFO fills to 8 and refuses more.
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = 8'(i);
      @(negedge clk);
    end
    chk("burst_count_full", 32'(fifo_count), 32'd8);
    chk("burst_ready_low", 32'(in_ready), 32'd0);
    in_data = 8'h77;
    repeat (3) @(negedge clk);
    chk("burst_full_refuse", 32'(fifo_count), 32'd8);
    in_valid = 1'b0;
    tp = -1;
    for (int i = 0; i < 9; i++) begin
      rx(0, $sformatf("burst_byte%0d", i), 8'(i), t);
      if (i > 0) chk($sformatf("burst_gap%0d", i), 32'(t - tp), 32'(F1));
      tp = t;
    end
    n = 0;
    while (busy === 1'b1 && n < 4000) begin @(negedge clk); n++; end
    chk("burst_no_extra_frame", 32'(q0_f.size()), 32'd0);

    // Push on the same edge the FSM pops with three bytes queued.
    in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk);
    in_data = 8'h22;
    @(negedge clk);
    p1 = cyc; in_data = 8'h33;
    @(negedge clk);
    in_data = 8'h44;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pp_count_before", 32'(fifo_count), 32'd3);
    wait_until(p1 + F1 - 1);
    chk("pp_still_stop", 32'(txd), 32'd1);
    chk("pp_count_pre_edge", 32'(fifo_count), 32'd3);
    in_data = 8'h5E; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pp_count_same", 32'(fifo_count), 32'd3);
    chk("pp_next_start", 32'(txd), 32'd0);
    rx(0, "pp_b0", 8'h11, tp);
    rx(0, "pp_b1", 8'h22, t);  chk("pp_gap1", 32'(t - tp), 32'(F1)); tp = t;
    rx(0, "pp_b2", 8'h33, t);  chk("pp_gap2", 32'(t - tp), 32'(F1)); tp = t;
    rx(0, "pp_b3", 8'h44, t);  chk("pp_gap3", 32'(t - tp), 32'(F1)); tp = t;
    rx(0, "pp_b4", 8'h5E, t);  chk("pp_gap4", 32'(t - tp), 32'(F1));
    n = 0;
    while (busy === 1'b1 && n < 4000) begin @(negedge clk); n++; end

    // Reset 1000 cycles into a frame with three bytes queued.
    in_valid = 1'b1;
    in_data = 8'hC3; @(negedge clk);
    in_data = 8'h3C; @(negedge clk);
    in_data = 8'h0F; @(negedge clk);
    in_data = 8'hF0; @(negedge clk);
    in_valid = 1'b0;
    repeat (1000) @(negedge clk);
    chk("mrst_count_before", 32'(fifo_count), 32'd3);
    s0 = starts0; qs = q0_f.size();
    rst = 1'b1;
    #1;
    chk("mrst_txd_high", 32'(txd), 32'd1);
    chk("mrst_count_zero", 32'(fifo_count), 32'd0);
    chk("mrst_busy_low", 32'(busy), 32'd0);
    chk("mrst_ready_high", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5000) @(negedge clk);
    chk("mrst_no_new_start", 32'(starts0), 32'(s0));
    chk("mrst_no_frame", 32'(q0_f.size()), 32'(qs));
    chk("mrst_idle_txd", 32'(txd), 32'd1);
    in_data = 8'h81; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rx(0, "mrst_after_push", 8'h81, t);

    // Two stop bits: 0x55 then 0xFF, stop held 434 cycles before the next start.
    in_data2 = 8'h55; in_valid2 = 1'b1;
    @(negedge clk);
    t2 = cyc; in_data2 = 8'hFF;
    @(negedge clk);
    in_valid2 = 1'b0;
    s = t2 + 1 + (9 + P) * CPB;
    wait_until(s - 1);
    chk("sb2_last_bit_low", 32'(txd2), 32'd0);
    @(negedge clk);
    chk("sb2_stop_begin", 32'(txd2), 32'd1);
    wait_until(s + 2 * CPB - 1);
    chk("sb2_stop_end", 32'(txd2), 32'd1);
    @(negedge clk);
    chk("sb2_next_start", 32'(txd2), 32'd0);
    rx(1, "sb2_b0", 8'h55, tp);
    rx(1, "sb2_b1", 8'hFF, t);
    chk("sb2_gap", 32'(t - tp), 32'(F2));

    // Bytes with odd and even bit counts (parity 1 and 0 when parity is built in).
    in_valid = 1'b1; in_data = 8'h07;
    @(negedge clk);
    in_data = 8'h03;
    @(negedge clk);
    in_valid = 1'b0;
    rx(0, "par_07", 8'h07, tp);
    rx(0, "par_03", 8'h03, t);
    chk("par_gap", 32'(t - tp), 32'(F1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
